// File: rtl/magia_l2_responder.sv
// magia_l2_responder: L2 endpoint serving word read/write requests from a local SRAM with fixed-latency, in-order responses.
// Optional access statistics outputs are enabled by defining MAGIA_L2_RESPONDER_STATS_EN.
module magia_l2_responder #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ID_W      = 4,
    parameter int unsigned       N_WORDS   = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'hC000_0000,
    parameter int unsigned       LATENCY   = 2,
    parameter int unsigned       RSP_DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic                req_we_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    input  logic [DATA_W/8-1:0] req_be_i,
    input  logic [ID_W-1:0]     req_id_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic [ID_W-1:0]     rsp_id_o,
`ifdef MAGIA_L2_RESPONDER_STATS_EN
    output logic [31:0]         stat_rd_o,
    output logic [31:0]         stat_wr_o,
    output logic [31:0]         stat_err_o,
`endif
    output logic                rsp_err_o
);
    localparam int unsigned IW = $clog2(N_WORDS);
    localparam int unsigned PW = $clog2(RSP_DEPTH);
    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
    localparam logic [ADDR_W:0] END_ADDR = {1'b0, BASE_ADDR} + (ADDR_W + 1)'(N_WORDS * 4);

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic              err;
        logic [DATA_W-1:0] rdata;
    } rsp_t;

    typedef struct packed {
        logic v;
        rsp_t r;
    } stage_t;

    logic [DATA_W-1:0] mem [N_WORDS];
    rsp_t              fifo [RSP_DEPTH];
    logic [PW:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]     outstanding;
    logic              accept, pop, err;
    logic [IW-1:0]     idx;
    stage_t            s0, last;
    rsp_t              head;

    assign req_ready_o = outstanding != CW'(RSP_DEPTH);
    assign accept      = req_valid_i & req_ready_o;
    assign err         = req_addr_i < BASE_ADDR || {1'b0, req_addr_i} >= END_ADDR || req_addr_i[1:0] != 2'b00;
    assign idx         = IW'((req_addr_i - BASE_ADDR) >> 2);
    assign rsp_valid_o = wr_ptr != rd_ptr;
    assign pop         = rsp_valid_o & rsp_ready_i;
    assign head        = fifo[rd_ptr[PW-1:0]];
    assign rsp_id_o    = rsp_valid_o ? head.id : '0;
    assign rsp_err_o   = rsp_valid_o & head.err;
    assign rsp_rdata_o = rsp_valid_o ? head.rdata : '0;

    // Accept-cycle stage: read data comes from the array before this cycle's write lands
    always_comb begin
        s0.v       = accept;
        s0.r.id    = req_id_i;
        s0.r.err   = err;
        s0.r.rdata = (req_we_i | err) ? '0 : mem[idx];
    end

    if (LATENCY == 1) begin : g_direct
        assign last = s0;
    end else begin : g_pipe
        stage_t q [LATENCY-1];
        // Fixed-latency shift register; never stalls because credits reserve FIFO room
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < LATENCY - 1; i++) q[i] <= '0;
            end else begin
                q[0] <= s0;
                for (int i = 1; i < LATENCY - 1; i++) q[i] <= q[i-1];
            end
        end
        assign last = q[LATENCY-2];
    end

    // SRAM byte-enabled write; errored accesses never touch the array
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DATA_W / 8; i++)
            if (accept & req_we_i & ~err & req_be_i[i]) mem[idx][8*i +: 8] <= req_wdata_i[8*i +: 8];
    end

    // Response FIFO storage, written by the last pipeline stage
    always_ff @(posedge clk_i) begin
        if (last.v) fifo[wr_ptr[PW-1:0]] <= last.r;
    end

    // FIFO pointers and outstanding-transaction credit counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
        end else begin
            wr_ptr      <= wr_ptr + (PW + 1)'(last.v);
            rd_ptr      <= rd_ptr + (PW + 1)'(pop);
            outstanding <= outstanding + CW'(accept) - CW'(pop);
        end
    end

`ifdef MAGIA_L2_RESPONDER_STATS_EN
    // Saturating counters of accepted reads, writes and errored accesses
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_rd_o  <= '0;
            stat_wr_o  <= '0;
            stat_err_o <= '0;
        end else begin
            if (accept & ~req_we_i & ~err & (stat_rd_o != '1)) stat_rd_o <= stat_rd_o + 32'd1;
            if (accept & req_we_i & ~err & (stat_wr_o != '1)) stat_wr_o <= stat_wr_o + 32'd1;
            if (accept & err & (stat_err_o != '1)) stat_err_o <= stat_err_o + 32'd1;
        end
    end
`endif
endmodule

// File: doc/magia_l2_responder.md
Name: magia_l2_responder

Overview:
- L2-side endpoint for one mesh row's L2 port, i.e. the target of the requests the mesh emits toward L2.
- Accepts word-granular read/write requests on a valid/ready channel and services them from a local SRAM model.
- Returns in-order responses, carrying the request ID, after a fixed pipeline latency.
- One instance per tile row (N_TILES_Y instances) at the west mesh edge, behind the floo-to-flat adapter, in both the mesh fixture and FPGA builds.

Parameters:
- ADDR_W, 32, request address width (bytes).
- DATA_W, 32, data width; fixed to 32 in this block.
- ID_W, 4, transaction ID width, echoed on the response.
- N_WORDS, 1024, SRAM depth in 32-bit words.
- BASE_ADDR, 32'hC000_0000, byte address of word 0.
- LATENCY, 2, cycles from request accept to response valid; legal range 1..8.
- RSP_DEPTH, 4, response FIFO depth and maximum number of outstanding transactions; power of 2.

Ports:
- clk_i, in, 1: clock.
- rst_ni, in, 1: reset.
- req_valid_i, in, 1: request valid.
- req_ready_o, out, 1: request ready.
- req_addr_i, in, ADDR_W: byte address.
- req_we_i, in, 1: 1 = write, 0 = read.
- req_wdata_i, in, 32: write data.
- req_be_i, in, 4: byte enables.
- req_id_i, in, ID_W: transaction ID.
- rsp_valid_o, out, 1: response valid.
- rsp_ready_i, in, 1: response ready.
- rsp_rdata_o, out, 32: read data; 0 for writes and errors.
- rsp_id_o, out, ID_W: echoed ID.
- rsp_err_o, out, 1: access error.
- Clocking/reset (already decided): one clock, clk_i; reset rst_ni is asynchronous and active-low.

Behaviour:
- Reset values: req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_id_o=0, rsp_err_o=0. Credit counter, pipeline valids and FIFO pointers clear to 0. SRAM contents are not reset.
- Accept: a request is accepted when req_valid_i & req_ready_o on a rising edge. Request fields must be held stable while valid is high and ready is low. Valid must not drop before the handshake.
- Credit: outstanding counter (0..RSP_DEPTH) counts accepted requests whose response has not yet handshaked.
  - +1 on accept, -1 on response handshake; both in the same cycle leaves it unchanged.
  - req_ready_o = (outstanding != RSP_DEPTH), registered-free combinational compare. The FIFO therefore never overflows.
- Decode: err = address below BASE_ADDR, address at or above BASE_ADDR + 4*N_WORDS, or addr[1:0] != 0. Index = (addr - BASE_ADDR) >> 2.
- SRAM access happens in the accept cycle.
  - Write: bytes with be[i]=1 are updated on the clock edge; be=0 is a legal no-op write.
  - Read: data is captured into pipeline stage 0 from the pre-write array contents. A read to the same address in the next cycle returns the new data.
  - Errored accesses do not write.
- Pipeline: LATENCY-deep shift register of {valid, id, err, we, rdata}; stage 0 is loaded at accept. The last stage pushes into the response FIFO.
- FIFO is fall-through: an entry pushed at the end of cycle t+LATENCY-1 shows rsp_valid_o=1 in cycle t+LATENCY, where t is the accept cycle.
  - With rsp_ready_i held high, throughput is 1 response/cycle.
  - Simultaneous push and pop is legal when the FIFO is full.
- Response outputs come straight from the FIFO head. They hold stable while rsp_valid_o & !rsp_ready_i. Responses leave in acceptance order.
- rsp_rdata_o = 0 when we=1 or err=1.
- Reset mid-operation clears all in-flight and queued responses; SRAM keeps its contents.

Optional Feature:
- Macro: MAGIA_L2_RESPONDER_STATS_EN.
- When defined:
  - Adds outputs stat_rd_o[31:0], stat_wr_o[31:0] and stat_err_o[31:0].
  - Each counts accepted non-error reads, non-error writes and errored accesses respectively.
  - Counters saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Write 0xDEADBEEF, be=4'hF, id=3 to 0xC000_0010, then read id=5 from the same address. Expect a write response {id=3, err=0, rdata=0} at t+2, then a read response {id=5, rdata=0xDEADBEEF}.
- Partial write: after the above, write 0x00AA0000 with be=4'b0100, then read. Expect rdata=0xDEAABEEF.
- Errors: reads at 0xBFFF_FFFC, 0xC000_1000 and 0xC000_0002. Expect err=1 and rdata=0 for each; the SRAM is unmodified (a subsequent read of 0xC000_0000 returns its prior value).
- Backpressure: rsp_ready_i=0, then 6 back-to-back reads. req_ready_o must drop after 4 accepts. Then raise rsp_ready_i: 4 responses appear in ID order, req_ready_o re-asserts, all 6 complete and none are lost.
- Streaming: 16 consecutive reads with rsp_ready_i=1. After the first response at t+2, one response arrives per cycle and req_ready_o stays 1 throughout.
- Assert rst_ni low with 3 responses queued. Expect rsp_valid_o=0 and req_ready_o=1 after reset; a subsequent read returns the data written before the reset.
